run_controller: RTL

- Run-control sequencer for the 9-bit single-cycle processor.
- Owns the start/ack handshake with the testbench, gates instruction issue (forces NOP when not running), and holds the PC at 0 until a run begins.
- Counts executed cycles and enforces a cycle-budget watchdog.
- Sits between the testbench handshake pins and the fetch/decode path; replaces the ad-hoc ever_start/start_off/overflow logic.

---
 rtl/run_ctrl_pkg.sv | 20 ++
 rtl/cycle_counter.sv | 35 +++
 rtl/run_controller.sv | 123 ++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run-control sequencer of the 9-bit processor.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } run_state_e;

    localparam logic [8:0] NOP_INSTR           = 9'b1_0000_0000;
    localparam int         DEFAULT_CNT_W       = 16;
    localparam int         DEFAULT_CYCLE_LIMIT = 4096;

    // PC is held (zeroed or frozen) in every state except RUN.
    function automatic logic holds_pc(input run_state_e st);
        return (st != RUN);
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// Cycle counter with synchronous clear, count enable and terminal-count compare.
module cycle_counter #(
    parameter int CNT_W    = 16,
    parameter int TERMINAL = 4095
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             at_terminal
);

    localparam logic [CNT_W-1:0] TERMINAL_C = CNT_W'(TERMINAL);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

    logic [CNT_W-1:0] count_r;

    // Count register: clear has priority over enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + ONE_C;
        end else begin
            count_r <= count_r;
        end
    end

    assign count       = count_r;
    assign at_terminal = (count_r == TERMINAL_C);

endmodule

// File: rtl/run_controller.sv
// Run-control sequencer: start/ack handshake, issue gating, PC hold and cycle watchdog.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int CYCLE_LIMIT = DEFAULT_CYCLE_LIMIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             done,
    output logic             run_en,
    output logic             pc_hold,
    output logic             ack,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    run_state_e state_r;
    run_state_e state_next_s;
    logic       ack_r;
    logic       ack_next_s;
    logic       timeout_r;
    logic       timeout_next_s;
    logic       run_en_r;
    logic       pc_hold_r;
    logic       cnt_clear_s;
    logic       cnt_enable_s;
    logic       cnt_terminal_s;

    // The terminal compare fires on the last allowed RUN cycle, so the
    // counter stops at CYCLE_LIMIT and can never wrap.
    cycle_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (CYCLE_LIMIT - 1)
    ) u_cycle_counter (
        .clk         (clk),
        .reset       (reset),
        .clear       (cnt_clear_s),
        .enable      (cnt_enable_s),
        .count       (cycle_count),
        .at_terminal (cnt_terminal_s)
    );

    // Next-state, handshake flag and counter control decode.
    always_comb begin
        state_next_s   = state_r;
        ack_next_s     = ack_r;
        timeout_next_s = timeout_r;
        cnt_clear_s    = 1'b0;
        cnt_enable_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = ARMED;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ARMED: begin
                if (!start) begin
                    state_next_s = RUN;
                    cnt_clear_s  = 1'b1;
                end else begin
                    state_next_s = ARMED;
                end
            end
            RUN: begin
                cnt_enable_s = 1'b1;
                // done takes precedence over the watchdog in the same cycle
                if (done) begin
                    state_next_s   = FINISH;
                    ack_next_s     = 1'b1;
                    timeout_next_s = 1'b0;
                end else if (cnt_terminal_s) begin
                    state_next_s   = FINISH;
                    ack_next_s     = 1'b1;
                    timeout_next_s = 1'b1;
                end else begin
                    state_next_s = RUN;
                end
            end
            FINISH: begin
                if (start) begin
                    state_next_s   = ARMED;
                    ack_next_s     = 1'b0;
                    timeout_next_s = 1'b0;
                end else begin
                    state_next_s = FINISH;
                end
            end
            default: begin
                state_next_s   = IDLE;
                ack_next_s     = 1'b0;
                timeout_next_s = 1'b0;
            end
        endcase
    end

    // State and output registers; run_en/pc_hold are decoded from the next
    // state so they stay aligned with state_r.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            ack_r     <= 1'b0;
            timeout_r <= 1'b0;
            run_en_r  <= 1'b0;
            pc_hold_r <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            ack_r     <= ack_next_s;
            timeout_r <= timeout_next_s;
            run_en_r  <= (state_next_s == RUN);
            pc_hold_r <= holds_pc(state_next_s);
        end
    end

    assign run_en  = run_en_r;
    assign pc_hold = pc_hold_r;
    assign ack     = ack_r;
    assign timeout = timeout_r;

endmodule
